// File: rtl/alu_rv32_pkg.sv
// Shared definitions for the alu_rv32 block.
//   - OP_* : 3-bit AluControl opcode values
//   - FLAG_* : bit positions inside the 3-bit Flag output
// Optional feature macro used by the block: ALU_RV32_SHIFT_EN (enables SLL/SRL).
package alu_rv32_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SLT = 3'b101;
  localparam logic [OP_W-1:0] OP_SLL = 3'b110;
  localparam logic [OP_W-1:0] OP_SRL = 3'b111;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_CARRY = 2;

endpackage : alu_rv32_pkg

// File: rtl/alu_rv32_addsub.sv
// 33-bit add/subtract datapath shared by ADD, SUB and SLT.
// Ports:
//   a, b  : 32-bit operands
//   sub   : 0 -> a + b, 1 -> a + ~b + 1
//   sum   : low 32 bits of the result
//   cout  : adder bit 32 (carry-out; for subtract 1 means no borrow)
module alu_rv32_addsub
  import alu_rv32_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W-1:0] b_eff;

  // Subtraction reuses the same adder: invert b and inject the +1 as carry-in.
  assign b_eff       = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};

endmodule : alu_rv32_addsub

// File: rtl/alu_rv32.sv
// RV32-style ALU with a single registered output stage (one-cycle latency).
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset (outputs forced to zero)
//   scrA, scrB : 32-bit operands (scrB[4:0] is the shift amount)
//   AluControl : opcode (ADD SUB AND OR XOR SLT SLL SRL)
//   ALUresult  : registered result
//   Flag       : registered status {carry, negative, zero}
// Configuration: define ALU_RV32_SHIFT_EN to build the shifter for SLL/SRL;
// without it those opcodes produce a zero result.
module alu_rv32
  import alu_rv32_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] scrA,
  input  logic [DATA_W-1:0] scrB,
  input  logic [OP_W-1:0]   AluControl,
  output logic [DATA_W-1:0] ALUresult,
  output logic [FLAG_W-1:0] Flag
);

  logic              add_sub;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic              slt_lt;
  logic [DATA_W-1:0] result_d;
  logic              carry_d;
  logic [FLAG_W-1:0] flag_d;

  // SLT needs A - B, so it drives the adder in subtract mode as well.
  assign add_sub = (AluControl == OP_SUB) || (AluControl == OP_SLT);

  alu_rv32_addsub u_addsub (
    .a    (scrA),
    .b    (scrB),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Signed less-than immune to overflow: if the signs differ, A is smaller
  // exactly when A is negative; otherwise the difference cannot overflow and
  // its sign bit answers the question.
  assign slt_lt = (scrA[DATA_W-1] ^ scrB[DATA_W-1]) ? scrA[DATA_W-1]
                                                    : add_sum[DATA_W-1];

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    unique case (AluControl)
      OP_ADD: begin
        result_d = add_sum;
        carry_d  = add_cout;
      end
      OP_SUB: begin
        result_d = add_sum;
        carry_d  = add_cout;
      end
      OP_AND: result_d = scrA & scrB;
      OP_OR:  result_d = scrA | scrB;
      OP_XOR: result_d = scrA ^ scrB;
      OP_SLT: result_d = {{(DATA_W-1){1'b0}}, slt_lt};
`ifdef ALU_RV32_SHIFT_EN
      OP_SLL: result_d = scrA << scrB[4:0];
      OP_SRL: result_d = scrA >> scrB[4:0];
`else
      OP_SLL: result_d = '0;
      OP_SRL: result_d = '0;
`endif
      default: result_d = '0;
    endcase
  end

  always_comb begin
    flag_d             = '0;
    flag_d[FLAG_ZERO]  = (result_d == '0);
    flag_d[FLAG_NEG]   = result_d[DATA_W-1];
    flag_d[FLAG_CARRY] = carry_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // Reset deliberately clears the zero flag too, so Flag reads 000 in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALUresult <= '0;
      Flag      <= '0;
    end else begin
      ALUresult <= result_d;
      Flag      <= flag_d;
    end
  end

endmodule : alu_rv32

// File: tb/tb_alu_rv32.sv
// Self-checking bench for alu_rv32: directed vector table, reset / timing
// sequences, and randomized operations against a behavioural model.
module tb_alu_rv32;

  logic        clk;
  logic        rst_n;
  logic [31:0] scrA;
  logic [31:0] scrB;
  logic [2:0]  AluControl;
  logic [31:0] ALUresult;
  logic [2:0]  Flag;

  int n_compared   = 0;
  int n_mismatched = 0;

  alu_rv32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scrA       (scrA),
    .scrB       (scrB),
    .AluControl (AluControl),
    .ALUresult  (ALUresult),
    .Flag       (Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flag;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] exp_res,
                       input logic [2:0] exp_flag);
    n_compared++;
    if (ALUresult !== exp_res || Flag !== exp_flag) begin
      n_mismatched++;
      $display("FAIL %s: got result=%h flag=%b, expected result=%h flag=%b",
               name, ALUresult, Flag, exp_res, exp_flag);
    end
  endtask

  // Reference model built directly from the operation definitions.
  function automatic logic [34:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic        c;
    r = 32'h0;
    c = 1'b0;
    case (op)
      3'b000: begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32]; end
      3'b001: begin r = a - b; c = (a >= b); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
`ifdef ALU_RV32_SHIFT_EN
      3'b110: r = a << b[4:0];
      3'b111: r = a >> b[4:0];
`else
      3'b110: r = 32'h0;
      3'b111: r = 32'h0;
`endif
      default: r = 32'h0;
    endcase
    return {c, r[31], (r == 32'h0), r};
  endfunction

  // Drive on the falling edge, let the DUT sample on the rising edge,
  // then look at the outputs shortly after.
  task automatic apply(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    AluControl = op;
    scrA       = a;
    scrB       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [34:0] exp;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    vecs.push_back('{"add_req",    3'b000, 32'h00200476, 32'hFFFFFFFC, 32'h00200472, 3'b100});
    vecs.push_back('{"add_wrap",   3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 3'b101});
    vecs.push_back('{"add_small",  3'b000, 32'h00000002, 32'h00000003, 32'h00000005, 3'b000});
    vecs.push_back('{"xor_req",    3'b100, 32'h00000035, 32'h00000034, 32'h00000001, 3'b000});
    vecs.push_back('{"sub_zero",   3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 3'b101});
    vecs.push_back('{"sub_borrow", 3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 3'b010});
    vecs.push_back('{"and",        3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 3'b000});
    vecs.push_back('{"or_neg",     3'b011, 32'h80000000, 32'h00000001, 32'h80000001, 3'b010});
    vecs.push_back('{"slt_m1_1",   3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 3'b000});
    vecs.push_back('{"slt_1_m1",   3'b101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 3'b001});
    vecs.push_back('{"slt_ovf",    3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 3'b000});
`ifdef ALU_RV32_SHIFT_EN
    vecs.push_back('{"sll",        3'b110, 32'h80000001, 32'h00000021, 32'h00000002, 3'b000});
    vecs.push_back('{"srl",        3'b111, 32'h80000001, 32'h00000021, 32'h40000000, 3'b000});
    vecs.push_back('{"sll_31",     3'b110, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 3'b010});
`else
    vecs.push_back('{"sll_off",    3'b110, 32'h80000001, 32'h00000021, 32'h00000000, 3'b001});
    vecs.push_back('{"srl_off",    3'b111, 32'h80000001, 32'h00000021, 32'h00000000, 3'b001});
`endif

    // Reset held two cycles with inputs that would otherwise be non-zero.
    rst_n      = 1'b0;
    scrA       = 32'hFFFFFFFF;
    scrB       = 32'h00000001;
    AluControl = 3'b000;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset", 32'h0, 3'b000);
    end

    // First edge after release registers a real result.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", 32'h00000000, 3'b101);

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].res, vecs[i].flag);
    end

    // Inputs changing between edges must not disturb the registered outputs.
    apply(3'b000, 32'h00000010, 32'h00000020);
    check("hold_before", 32'h00000030, 3'b000);
    scrA       = 32'hDEADBEEF;
    AluControl = 3'b001;
    #2;
    check("hold_mid_cycle", 32'h00000030, 3'b000);
    @(posedge clk);
    #1;
    exp = model(3'b001, 32'hDEADBEEF, 32'h00000020);
    check("after_change", exp[31:0], exp[34:32]);

    // Reset asserted mid-stream discards the operation presented with it.
    @(negedge clk);
    rst_n      = 1'b0;
    AluControl = 3'b011;
    scrA       = 32'h12345678;
    scrB       = 32'h0;
    @(posedge clk);
    #1;
    check("midstream_reset", 32'h0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("resume_after_reset", 32'h12345678, 3'b000);

    // Randomized operations, with some operands drawn from corner values.
    for (int k = 0; k < 300; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'h80000000;
        2: rb = 32'h7FFFFFFF;
        3: ra = 32'hFFFFFFFF;
        default: ;
      endcase
      apply(rop, ra, rb);
      exp = model(rop, ra, rb);
      check($sformatf("rand%0d_op%0d", k, rop), exp[31:0], exp[34:32]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_alu_rv32
